// File: rtl/if_pkg.sv
// ----------------------------------------------------------------------------
// if_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_e : fetch FSM states (REQ, KILL, BLOCKED)
//   fetch_word_t  : {instr, pc4} payload held in IF/ID and in the skid buffer
//   NOP_INSTR, OPC_J, PC_INC : fetch constants
// ----------------------------------------------------------------------------
package if_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 6;

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_KILL    = 2'd1,
    ST_BLOCKED = 2'd2
  } fetch_state_e;

  localparam logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0000;
  localparam logic [OPC_W-1:0] OPC_J     = 6'b000010;
  localparam logic [XLEN-1:0]  PC_INC    = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
  } fetch_word_t;

  // Major opcode field of an instruction word.
  function automatic logic [OPC_W-1:0] opcode_of(input logic [XLEN-1:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// ----------------------------------------------------------------------------
// if_fetch_stage_if: instruction-memory req/rvalid bus.
//   imem_req    : fetch request, held until imem_rvalid
//   imem_addr   : word fetch address, stable while imem_req is high
//   imem_rvalid : one response per request
//   imem_rdata  : instruction word, valid with imem_rvalid
// Modports: master (fetch stage), slave (instruction memory).
// ----------------------------------------------------------------------------
interface if_fetch_stage_if;
  import if_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/if_skid_buf.sv
// ----------------------------------------------------------------------------
// if_skid_buf: one-entry {instr, pc4} holding register that absorbs a fetched
// word while decode is stalled.
//   clk, reset : clock, synchronous active-high reset
//   load_i     : capture word_i
//   clear_i    : drop the held word (wins over load_i)
//   word_i     : incoming {instr, pc4}
//   valid_o    : a word is held
//   word_o     : held {instr, pc4}
// ----------------------------------------------------------------------------
module if_skid_buf
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        clear_i,
  input  fetch_word_t word_i,
  output logic        valid_o,
  output fetch_word_t word_o
);

  logic        valid_q;
  fetch_word_t word_q;

  // Holding register.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      word_q  <= word_i;
    end
  end

  assign valid_o = valid_q;
  assign word_o  = word_q;

endmodule

// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage: instruction-fetch stage plus IF/ID pipeline register.
// Holds the PC, issues word fetches over a variable-latency req/rvalid bus,
// absorbs decode stalls with a one-entry skid buffer and handles downstream
// redirects, including killing an in-flight fetch.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   imem            : instruction-memory bus (master modport)
//   stall_id        : decode cannot accept a new instruction
//   redirect_valid  : taken branch/jump resolved downstream
//   redirect_pc     : redirect target, bits [1:0] ignored
//   id_valid        : IF/ID holds a live instruction
//   id_instr        : IF/ID instruction (NOP when not valid)
//   id_opcode       : id_instr[31:26], combinational
//   id_jump_done    : (IF_EARLY_JUMP_EN only) the IF/ID j was already taken
//   id_pc4          : PC+4 of the IF/ID instruction
//
// Build option: define IF_EARLY_JUMP_EN to redirect the PC at fetch time for
// j instructions (opcode 000010) and add the id_jump_done output.
// ----------------------------------------------------------------------------
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  if_fetch_stage_if.master     imem,
  input  logic                 stall_id,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_pc,
  output logic                 id_valid,
  output logic [XLEN-1:0]      id_instr,
  output logic [OPC_W-1:0]     id_opcode,
`ifdef IF_EARLY_JUMP_EN
  output logic                 id_jump_done,
`endif
  output logic [XLEN-1:0]      id_pc4
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            req_q, req_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_instr_q, id_instr_d;
  logic [XLEN-1:0] id_pc4_q, id_pc4_d;
  logic            jump_done_q, jump_done_d;

  logic            rsp;
  logic            accept;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] fetch_next_pc;
  logic            rsp_is_j;
  logic            skid_is_j;

  logic            skid_load, skid_clear, skid_valid;
  fetch_word_t     skid_in, skid_out;

  // Target bits [1:0] are forced to 00.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // A response only counts while our request is actually up; this also drops
  // a late answer to a request abandoned by reset.
  assign rsp    = imem.imem_rvalid & req_q;
  assign accept = !id_valid_q || !stall_id;
  assign pc_inc = pc_q + PC_INC;

  assign rsp_is_j  = (opcode_of(imem.imem_rdata) == OPC_J);
  assign skid_is_j = (opcode_of(skid_out.instr) == OPC_J);

  // PC following a fetched word: sequential, or the j target when enabled.
`ifdef IF_EARLY_JUMP_EN
  assign fetch_next_pc = rsp_is_j ? {pc_inc[31:28], imem.imem_rdata[25:0], 2'b00}
                                  : pc_inc;
`else
  assign fetch_next_pc = pc_inc;
`endif

  assign skid_in.instr = imem.imem_rdata;
  assign skid_in.pc4   = pc_inc;

  if_skid_buf u_skid (
    .clk     (clk),
    .reset   (reset),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .word_i  (skid_in),
    .valid_o (skid_valid),
    .word_o  (skid_out)
  );

  // State register and IF/ID datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      req_q       <= 1'b0;
      id_valid_q  <= 1'b0;
      id_instr_q  <= NOP_INSTR;
      id_pc4_q    <= '0;
      jump_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      id_valid_q  <= id_valid_d;
      id_instr_q  <= id_instr_d;
      id_pc4_q    <= id_pc4_d;
      jump_done_q <= jump_done_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    id_valid_d  = id_valid_q;
    id_instr_d  = id_instr_q;
    id_pc4_d    = id_pc4_q;
    jump_done_d = jump_done_q;
    skid_load   = 1'b0;
    skid_clear  = 1'b0;

    // Decode consumed the IF/ID word; empty unless refilled below.
    if (id_valid_q && !stall_id) begin
      id_valid_d  = 1'b0;
      id_instr_d  = NOP_INSTR;
      jump_done_d = 1'b0;
    end

    if (redirect_valid) begin
      // Flush wins over stall; an outstanding fetch must be drained in KILL.
      pc_d        = {redirect_pc[31:2], 2'b00};
      id_valid_d  = 1'b0;
      id_instr_d  = NOP_INSTR;
      jump_done_d = 1'b0;
      skid_clear  = 1'b1;
      state_d     = (req_q && !rsp) ? ST_KILL : ST_REQ;
    end else begin
      case (state_q)
        ST_REQ: begin
          if (rsp) begin
            pc_d = fetch_next_pc;
            if (accept) begin
              id_valid_d  = 1'b1;
              id_instr_d  = imem.imem_rdata;
              id_pc4_d    = pc_inc;
              jump_done_d = (fetch_next_pc != pc_inc) && rsp_is_j;
            end else begin
              skid_load = 1'b1;
              state_d   = ST_BLOCKED;
            end
          end
        end
        ST_BLOCKED: begin
          if (!stall_id && skid_valid) begin
            id_valid_d  = 1'b1;
            id_instr_d  = skid_out.instr;
            id_pc4_d    = skid_out.pc4;
`ifdef IF_EARLY_JUMP_EN
            jump_done_d = skid_is_j;
`else
            jump_done_d = 1'b0;
`endif
            skid_clear  = 1'b1;
            state_d     = ST_REQ;
          end
        end
        ST_KILL: begin
          if (rsp) begin
            state_d = ST_REQ;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end

    // Address moves only when no request is outstanding or one just completed.
    addr_d = (!req_q || rsp) ? pc_d : addr_q;
    req_d  = (state_d != ST_BLOCKED);
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign id_valid       = id_valid_q;
  assign id_instr       = id_instr_q;
  assign id_opcode      = opcode_of(id_instr_q);
  assign id_pc4         = id_pc4_q;
`ifdef IF_EARLY_JUMP_EN
  assign id_jump_done   = jump_done_q;
`else
  logic unused_jump;
  assign unused_jump = jump_done_q ^ skid_is_j;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_stage: directed bench for if_fetch_stage. The instruction
// memory is driven by hand, one step per clock.
// ----------------------------------------------------------------------------
module tb_if_fetch_stage;
  import if_pkg::*;

  logic        clk;
  logic        reset;
  logic        stall_id;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [5:0]  id_opcode;
  logic [31:0] id_pc4;
`ifdef IF_EARLY_JUMP_EN
  logic        id_jump_done;
`endif

  int n_chk;
  int n_pass;

  if_fetch_stage_if mem_if ();

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem           (mem_if),
    .stall_id       (stall_id),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_opcode      (id_opcode),
`ifdef IF_EARLY_JUMP_EN
    .id_jump_done   (id_jump_done),
`endif
    .id_pc4         (id_pc4)
  );

  always #5 clk = ~clk;

  // Advance one clock, then settle past the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic mem(input logic v, input logic [31:0] d);
    mem_if.imem_rvalid = v;
    mem_if.imem_rdata  = d;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    stall_id       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem(1'b0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    clk    = 1'b0;
    n_chk  = 0;
    n_pass = 0;

    // Reset values.
    reset          = 1'b1;
    stall_id       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem(1'b0, 32'h0);
    tick();
    tick();
    chk("rst_req",      32'(mem_if.imem_req), 32'h0);
    chk("rst_id_valid", 32'(id_valid),        32'h0);
    chk("rst_id_instr", id_instr,             32'h0);
    chk("rst_id_pc4",   id_pc4,               32'h0);
    chk("rst_addr",     mem_if.imem_addr,     32'h0);

    // First cycle after reset: request not yet up, a stray rvalid is ignored.
    reset = 1'b0;
    mem(1'b1, 32'hDEAD_BEEF);
    tick();
    chk("post_rst_req",     32'(mem_if.imem_req), 32'h1);
    chk("post_rst_addr",    mem_if.imem_addr,     32'h0);
    chk("post_rst_ignored", 32'(id_valid),        32'h0);

    // Stream: data = addr, answered every cycle.
    mem(1'b1, 32'h0);
    tick();
    chk("s0_valid", 32'(id_valid),    32'h1);
    chk("s0_pc4",   id_pc4,           32'h4);
    chk("s0_addr",  mem_if.imem_addr, 32'h4);
    mem(1'b1, 32'h4);
    tick();
    chk("s1_pc4",   id_pc4,           32'h8);
    chk("s1_instr", id_instr,         32'h4);
    chk("s1_addr",  mem_if.imem_addr, 32'h8);
    mem(1'b1, 32'h8);
    tick();
    chk("s2_pc4",   id_pc4,           32'hC);
    chk("s2_addr",  mem_if.imem_addr, 32'hC);
    mem(1'b1, 32'hC);
    tick();
    chk("s3_pc4",   id_pc4,           32'h10);
    chk("s3_instr", id_instr,         32'hC);

    // Stall into skid while the addr-8 word returns.
    do_reset();
    mem(1'b1, 32'h0);
    tick();
    mem(1'b1, 32'h4);
    tick();
    chk("k_addr8", mem_if.imem_addr, 32'h8);
    stall_id = 1'b1;
    mem(1'b1, 32'h8);
    tick();
    chk("k_hold_instr", id_instr,              32'h4);
    chk("k_hold_pc4",   id_pc4,                32'h8);
    chk("k_req_low",    32'(mem_if.imem_req),  32'h0);
    mem(1'b0, 32'h0);
    tick();
    tick();
    chk("k_still_low",  32'(mem_if.imem_req),  32'h0);
    chk("k_still_hold", id_instr,              32'h4);
    stall_id = 1'b0;
    tick();
    chk("k_rel_instr", id_instr,              32'h8);
    chk("k_rel_pc4",   id_pc4,                32'hC);
    chk("k_rel_req",   32'(mem_if.imem_req),  32'h1);
    chk("k_rel_addr",  mem_if.imem_addr,      32'hC);
    mem(1'b1, 32'hC);
    tick();
    chk("k_resume_pc4", id_pc4, 32'h10);

    // Redirect while the addr-8 fetch is in flight (latency 3).
    do_reset();
    mem(1'b1, 32'h0);
    tick();
    mem(1'b1, 32'h4);
    tick();
    mem(1'b0, 32'h0);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    chk("r_stale_addr", mem_if.imem_addr,     32'h8);
    chk("r_stale_req",  32'(mem_if.imem_req), 32'h1);
    chk("r_flush",      32'(id_valid),        32'h0);
    redirect_valid = 1'b0;
    tick();
    mem(1'b1, 32'h8);
    tick();
    chk("r_drop_valid", 32'(id_valid),    32'h0);
    chk("r_drop_instr", id_instr,         32'h0);
    chk("r_new_addr",   mem_if.imem_addr, 32'h40);
    mem(1'b0, 32'h0);
    tick();
    mem(1'b1, 32'h40);
    tick();
    chk("r_pc4",   id_pc4,           32'h44);
    chk("r_instr", id_instr,         32'h40);
    chk("r_valid", 32'(id_valid),    32'h1);

    // Redirect and stall together with a live IF/ID word.
    stall_id       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    mem(1'b0, 32'h0);
    tick();
    chk("rs_valid", 32'(id_valid),    32'h0);
    chk("rs_instr", id_instr,         32'h0);
    chk("rs_addr",  mem_if.imem_addr, 32'h44);
    stall_id       = 1'b0;
    redirect_valid = 1'b0;
    mem(1'b1, 32'hDEAD_BEEF);
    tick();
    chk("rs_newpc", mem_if.imem_addr, 32'h80);
    chk("rs_drop",  32'(id_valid),    32'h0);

    // Unaligned target and PC wrap; response in the redirect cycle is dropped.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    mem(1'b1, 32'h1234_5678);
    tick();
    chk("w_addr",  mem_if.imem_addr, 32'hFFFF_FFFC);
    chk("w_drop",  32'(id_valid),    32'h0);
    redirect_valid = 1'b0;
    mem(1'b1, 32'h8C00_0010);
    tick();
    chk("w_pc4",    id_pc4,           32'h0);
    chk("w_instr",  id_instr,         32'h8C00_0010);
    chk("w_opcode", 32'(id_opcode),   32'h23);
    chk("w_next",   mem_if.imem_addr, 32'h0);

    // j 0x40 fetched from address 0.
    do_reset();
    mem(1'b1, 32'h0800_0010);
    tick();
    chk("j_opcode", 32'(id_opcode), 32'h2);
    chk("j_pc4",    id_pc4,         32'h4);
`ifdef IF_EARLY_JUMP_EN
    chk("j_next",   mem_if.imem_addr,  32'h40);
    chk("j_done",   32'(id_jump_done), 32'h1);
`else
    chk("j_next",   mem_if.imem_addr,  32'h4);
`endif
    mem(1'b1, 32'h0);
    tick();
`ifdef IF_EARLY_JUMP_EN
    chk("j_after_pc4",  id_pc4,            32'h44);
    chk("j_after_done", 32'(id_jump_done), 32'h0);
`else
    chk("j_after_pc4",  id_pc4,            32'h8);
`endif
    mem(1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register.
- Holds the PC and issues word fetches to instruction memory over a variable-latency req/rvalid interface.
- Presents the fetched instruction and its PC+4 to decode. id_opcode feeds the main control decoder's opcode input directly.
- Absorbs decode stalls with a one-entry skid buffer and handles branch/jump redirects from downstream, including killing an in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request; held high until imem_rvalid.
- imem_addr  output  32  fetch address; stable while imem_req is high.
- imem_rvalid  input  1  response valid; one per request, at least 1 cycle after imem_req rises.
- imem_rdata  input  32  instruction word, valid with imem_rvalid.
- stall_id  input  1  decode cannot accept a new instruction this cycle.
- redirect_valid  input  1  taken branch or jump resolved downstream.
- redirect_pc  input  32  new PC; bits [1:0] ignored, forced to 00.
- id_valid  output  1  IF/ID register holds a live instruction.
- id_instr  output  32  IF/ID instruction; 32'h0000_0000 (NOP) when id_valid=0.
- id_opcode  output  6  id_instr[31:26], combinational.
- id_pc4  output  32  PC+4 of the instruction in IF/ID.

Behaviour:
- Reset values (while reset=1, next edge): pc=RESET_PC, state=REQ, imem_req=0, id_valid=0, id_instr=0, id_pc4=0, skid empty. imem_req first rises the cycle after reset falls.
- States:
  - REQ: imem_req=1, imem_addr=pc.
  - KILL: imem_req=1 at the stale address; waits for rvalid, discards the data.
  - BLOCKED: imem_req=0; skid buffer holds a word.
- "accept" = !id_valid | !stall_id.
- Priority: reset > redirect_valid > rvalid/accept > stall.
- REQ & rvalid & accept: id_instr=rdata, id_pc4=pc+4, id_valid=1, pc=pc+4, stay in REQ. Back-to-back fetch; one instruction per cycle at 1-cycle memory latency.
- REQ & rvalid & !accept: skid={rdata, pc+4}, pc=pc+4, go to BLOCKED.
- BLOCKED & !stall_id: IF/ID loads from skid, skid cleared, go to REQ.
- IF/ID empties (id_valid=0, id_instr=0) when id_valid & !stall_id and no new word is loaded that cycle.
- Stall with id_valid=1 holds id_instr and id_pc4 unchanged.
- redirect_valid, any state:
  - pc=redirect_pc, id_valid=0, skid cleared. The flush overrides stall_id.
  - REQ & !rvalid goes to KILL.
  - REQ & rvalid same cycle: data dropped, stay in REQ at the new pc.
  - KILL: stay in KILL with the new pc latched.
  - BLOCKED goes to REQ.
- KILL & rvalid & !redirect: data dropped, go to REQ (pc already holds the target).
- A response arriving in KILL is never loaded into IF/ID or skid.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- imem_addr changes only on the cycle after rvalid or after leaving BLOCKED; never while a request is outstanding.
- Reset mid-fetch: the outstanding response is ignored. Memory must tolerate an abandoned request.

Optional Feature:
- Macro: IF_EARLY_JUMP_EN.
- Defined:
  - When a word with opcode 6'b000010 is loaded into IF/ID or skid, pc becomes {pc4[31:28], instr[25:0], 2'b00} instead of pc+4, saving one bubble per j.
  - Adds output id_jump_done (1 bit, reset 0), set alongside that instruction. Downstream suppresses its own redirect for it.
  - redirect_valid still overrides.
- Undefined:
  - Sequential pc+4 only. Jumps rely on redirect_valid.
  - id_jump_done is absent.

Decomposition:
- Shared package if_pkg:
  - fetch state enum {REQ, KILL, BLOCKED}.
  - NOP_INSTR = 32'h0.
  - OPC_J = 6'b000010.
  - PC_INC = 32'd4.
- Sub-module: if_skid_buf (one-entry {instr, pc4} holding register with load/clear/valid).
- Jump-target computation stays inline.

Test Plan:
- Stream:
  - Stimulus: reset, RESET_PC=0; memory answers 1 cycle after each request with data=addr.
  - Response: imem_addr 0,4,8,C on consecutive requests; id_pc4 4,8,C,10; id_opcode tracks rdata[31:26].
- Stall into skid:
  - Stimulus: stall_id=1 for 3 cycles while a word for addr 8 returns.
  - Response: IF/ID holds the addr-4 word; state BLOCKED, imem_req=0; after release, id_pc4=C, then a fetch at C resumes.
- Redirect in flight:
  - Stimulus: memory latency 3; redirect_valid with redirect_pc=32'h40 one cycle after the request to 8.
  - Response: the addr-8 data is discarded, id_valid=0; the next imem_addr is 40; id_pc4=44.
- Redirect vs stall:
  - Stimulus: redirect_valid=1 and stall_id=1 with id_valid=1 in the same cycle.
  - Response: id_valid=0 and id_instr=0 next cycle; pc=redirect_pc.
- Wrap and alignment:
  - Stimulus: redirect_pc=32'hFFFF_FFFE.
  - Response: imem_addr=FFFF_FFFC, id_pc4=0, next imem_addr=0.
- IF_EARLY_JUMP_EN:
  - Stimulus: instruction 32'h0800_0010 fetched from addr 0.
  - Response: next imem_addr=32'h40, id_jump_done=1 with it.
  - Without the macro: next imem_addr=4.
